// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word fetches under buffer credit, queues in-order
// responses in a small FIFO for decode, and flushes/drops stale work on redirect.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        i_clk,
    input  logic        i_arst,
    output logic        o_memReqValid,
    input  logic        i_memReqReady,
    output logic [31:0] o_memReqAddr,
    input  logic        i_memRspValid,
    input  logic [31:0] i_memRspData,
    input  logic        i_redirectEn,
    input  logic [31:0] i_redirectPc,
    output logic        o_instrValid,
    input  logic        i_instrReady,
    output logic [31:0] o_instr,
    output logic [31:0] o_instrPc,
    output logic [6:0]  o_operand,
    output logic [2:0]  o_funct3,
    output logic        o_funct7bit5
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    typedef logic [CntW-1:0] cnt_t;
    typedef logic [CntW:0]   sum_t;

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    // PC owed to the next response that will actually be kept
    logic [31:0]     rsp_pc_q, rsp_pc_d;
    cnt_t            count_q, count_d;
    cnt_t            outst_q, outst_d;
    cnt_t            drop_q, drop_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic            run_q;
    logic [31:0]     data_q [DEPTH];
    logic [31:0]     pc_q   [DEPTH];

    logic        req_hs, rsp_take, push, pop;
    logic [31:0] redirect_pc;
    logic [1:0]  unused_redirect_lo;

    assign redirect_pc        = {i_redirectPc[31:2], 2'b00};
    assign unused_redirect_lo = i_redirectPc[1:0];

    always_comb begin
        o_memReqValid = run_q && !i_redirectEn &&
                        ((sum_t'(count_q) + sum_t'(outst_q)) < sum_t'(DEPTH));
        o_memReqAddr  = fetch_pc_q;
        req_hs        = o_memReqValid && i_memReqReady;
        // With nothing outstanding a response belongs to no live request
        rsp_take      = i_memRspValid && (outst_q != '0);
        push          = rsp_take && (drop_q == '0) && !i_redirectEn;
        o_instrValid  = (count_q != '0);
        pop           = o_instrValid && i_instrReady && !i_redirectEn;
        o_instr       = o_instrValid ? data_q[rd_ptr_q] : '0;
        o_instrPc     = o_instrValid ? pc_q[rd_ptr_q] : '0;
        o_operand     = o_instr[6:0];
        o_funct3      = o_instr[14:12];
        o_funct7bit5  = o_instr[30];
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        count_d    = count_q + cnt_t'(push) - cnt_t'(pop);
        outst_d    = outst_q + cnt_t'(req_hs) - cnt_t'(rsp_take);
        drop_d     = drop_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (req_hs) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (rsp_take && (drop_q != '0)) begin
            drop_d = drop_q - cnt_t'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            rsp_pc_d = rsp_pc_q + 32'd4;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (i_redirectEn) begin
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            drop_d     = outst_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            run_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            run_q      <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            data_q[wr_ptr_q] <= i_memRspData;
            pc_q[wr_ptr_q]   <= rsp_pc_q;
        end
    end

    // Credit accounting makes a kept response into a full buffer impossible
    assert property (@(posedge i_clk) disable iff (i_arst)
        !(rsp_take && (drop_q == '0) && (count_q == cnt_t'(DEPTH))));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of fetch, in-flight requests and the decode buffer.
module tb_instr_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] XOR_KEY  = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        mem_req_valid, mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid, instr_ready = 1'b0;
    logic [31:0] instr, instr_pc;
    logic [6:0]  operand;
    logic [2:0]  funct3;
    logic        funct7bit5;

    instr_fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .i_clk         (clk),
        .i_arst        (arst),
        .o_memReqValid (mem_req_valid),
        .i_memReqReady (mem_req_ready),
        .o_memReqAddr  (mem_req_addr),
        .i_memRspValid (mem_rsp_valid),
        .i_memRspData  (mem_rsp_data),
        .i_redirectEn  (redirect_en),
        .i_redirectPc  (redirect_pc),
        .o_instrValid  (instr_valid),
        .i_instrReady  (instr_ready),
        .o_instr       (instr),
        .o_instrPc     (instr_pc),
        .o_operand     (operand),
        .o_funct3      (funct3),
        .o_funct7bit5  (funct7bit5)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] pc; bit stale;} req_t;
    typedef struct {logic [31:0] data; logic [31:0] pc;} ent_t;
    typedef struct {logic [31:0] addr; int due;} mem_t;

    req_t        m_infl[$];
    ent_t        m_buf[$];
    mem_t        mem_q[$];
    logic [31:0] m_pc = RESET_PC;
    bit          m_run = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          hs_count = 0;
    int          obs_out = 0;
    int          max_out = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, compare outputs, advance model to the edge.
    task automatic cycle(input bit redir, input logic [31:0] rpc, input bit mready,
                         input bit iready, input bit allow_rsp, input int lat);
        bit          rsp, exp_rv, exp_iv, hs, pop;
        logic [31:0] exp_instr, exp_ipc;
        req_t        r;
        @(negedge clk);
        rsp = allow_rsp && (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        redirect_en   = redir;
        redirect_pc   = rpc;
        mem_req_ready = mready;
        instr_ready   = iready;
        mem_rsp_valid = rsp;
        mem_rsp_data  = rsp ? (mem_q[0].addr ^ XOR_KEY) : $urandom;
        #1;
        exp_rv    = m_run && ((m_buf.size() + m_infl.size()) < DEPTH) && !redir;
        exp_iv    = (m_buf.size() != 0);
        exp_instr = exp_iv ? m_buf[0].data : 32'h0;
        exp_ipc   = exp_iv ? m_buf[0].pc : 32'h0;
        chk("req_valid", {31'b0, mem_req_valid}, {31'b0, exp_rv});
        chk("req_addr", mem_req_addr, m_pc);
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, exp_iv});
        chk("instr", instr, exp_instr);
        chk("instr_pc", instr_pc, exp_ipc);
        chk("operand", {25'b0, operand}, {25'b0, exp_instr[6:0]});
        chk("funct3", {29'b0, funct3}, {29'b0, exp_instr[14:12]});
        chk("funct7bit5", {31'b0, funct7bit5}, {31'b0, exp_instr[30]});
        // memory side follows what the DUT actually issued
        if (rsp) begin
            void'(mem_q.pop_front());
            if (obs_out > 0) obs_out--;
        end
        if (mem_req_valid && mready) begin
            mem_q.push_back('{addr: mem_req_addr, due: cyc + lat});
            hs_count++;
            obs_out++;
            if (obs_out > max_out) max_out = obs_out;
        end
        // reference model update
        hs  = exp_rv && mready;
        pop = exp_iv && iready && !redir;
        if (pop) void'(m_buf.pop_front());
        if (rsp && (m_infl.size() != 0)) begin
            r = m_infl.pop_front();
            if (!r.stale && !redir) m_buf.push_back('{data: r.pc ^ XOR_KEY, pc: r.pc});
        end
        if (redir) begin
            m_buf.delete();
            foreach (m_infl[i]) m_infl[i].stale = 1'b1;
            m_pc = {rpc[31:2], 2'b00};
        end
        if (hs) begin
            m_infl.push_back('{pc: m_pc, stale: 1'b0});
            m_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        cyc++;
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without waiting for a clock.
    task automatic do_reset();
        #3;
        arst          = 1'b1;
        redirect_en   = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        instr_ready   = 1'b0;
        #1;
        chk("rst_req_valid", {31'b0, mem_req_valid}, 32'h0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_req_addr", mem_req_addr, RESET_PC);
        m_buf.delete();
        m_infl.delete();
        m_pc     = RESET_PC;
        m_run    = 1'b0;
        hs_count = 0;
        obs_out  = 0;
        max_out  = 0;
        @(negedge clk);
        @(negedge clk);
        arst = 1'b0;
        #1;
        chk("release_req_valid", {31'b0, mem_req_valid}, 32'h0);
        chk("release_req_addr", mem_req_addr, RESET_PC);
        @(posedge clk);
        cyc++;
        m_run = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (mem_q.size() != 0 || m_buf.size() != 0); i++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        do_reset();

        // Streaming with everything ready, 1-cycle memory
        for (int i = 0; i < 30; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1);
        chk("max_outstanding_le_depth", {31'b0, (max_out <= DEPTH)}, 32'h1);
        drain();

        // Decode stall: credit limits accepted requests to DEPTH
        do_reset();
        for (int i = 0; i < 20; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1);
        chk("stall_accepts", hs_count, DEPTH);
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1);
        drain();

        // Two requests in flight, redirect before their responses
        cycle(1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 3);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 3);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 3);
        chk("two_outstanding", obs_out, 2);
        cycle(1'b1, 32'h103, 1'b1, 1'b1, 1'b0, 3);
        #1;
        chk("addr_after_redirect", mem_req_addr, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 3);
            #1;
            if (instr_valid) begin
                found = 1'b1;
                chk("first_pc_after_redirect", instr_pc, 32'h100);
            end
        end
        chk("redirect_delivery_seen", {31'b0, found}, 32'h1);

        // Redirect coincident with a response and a decode pop
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1);
        cycle(1'b1, 32'h200, 1'b1, 1'b1, 1'b1, 1);
        #1;
        chk("flush_empty", {31'b0, instr_valid}, 32'h0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1);
        drain();

        // Address wrap at the top of the space
        cycle(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1, 1);
        #1;
        chk("wrap_first_addr", mem_req_addr, 32'hFFFF_FFFC);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1);
        #1;
        chk("wrap_second_addr", mem_req_addr, 32'h0000_0000);
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1);
        drain();

        // Reset with two requests outstanding; late responses must vanish
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4);
        do_reset();
        for (int i = 0; i < 10 && mem_q.size() != 0; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1);
        end
        chk("late_rsp_ignored", {31'b0, instr_valid}, 32'h0);
        chk("late_rsp_drained", mem_q.size(), 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit          redir;
            logic [31:0] rpc;
            redir = ($urandom_range(0, 9) == 0);
            rpc   = $urandom;
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
            cycle(redir, rpc, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 3) != 0), $urandom_range(1, 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Produces the instruction stream that the single-cycle decode/control logic consumes.
- Sources 32-bit instructions from an instruction memory with variable latency using a valid/ready request port and an in-order response port.
- Buffers the instructions and presents them to decode with their PC and pre-split opcode/funct fields.
- Supports a branch/jump redirect that flushes the buffer and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, instruction buffer entries. This is also the maximum number of outstanding memory requests. Legal values are 2..8, power of two.

Ports:
- i_clk  input  1  clock.
- i_arst  input  1  asynchronous active-high reset.
- o_memReqValid  output  1  fetch request valid.
- i_memReqReady  input  1  memory accepts request.
- o_memReqAddr  output  32  word-aligned fetch address.
- i_memRspValid  input  1  response data valid; responses return in request order.
- i_memRspData  input  32  instruction word.
- i_redirectEn  input  1  redirect fetch, single-cycle pulse.
- i_redirectPc  input  32  redirect target; bits [1:0] are ignored and treated as 2'b00.
- o_instrValid  output  1  buffer head valid.
- i_instrReady  input  1  decode consumes head.
- o_instr  output  32  head instruction.
- o_instrPc  output  32  PC of head instruction.
- o_operand  output  7  o_instr[6:0].
- o_funct3  output  3  o_instr[14:12].
- o_funct7bit5  output  1  o_instr[30].

Behaviour:
Reset
- Reset is asynchronous on i_arst and active-high.
- While in reset: fetchPc = RESET_PC, buffer empty, outstanding = 0, dropCount = 0.
- Output reset values: o_memReqValid = 0, o_instrValid = 0, o_instr = 0, o_instrPc = 0, o_memReqAddr = RESET_PC.
- Reset mid-operation discards all buffered and in-flight state. Responses arriving after reset release count against nothing and are ignored.
- o_memReqValid may first assert on the first rising edge after release.

Request issue
- o_memReqValid = 1 iff (occupancy + outstanding) < DEPTH and i_redirectEn = 0. This is combinational credit.
- o_memReqAddr = fetchPc.
- On a handshake (valid & ready): outstanding += 1 and fetchPc += 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
- o_memReqValid is held with a stable address until accepted, except when a redirect occurs.

Response handling
- On i_memRspValid with dropCount > 0: discard the response, dropCount -= 1, outstanding -= 1.
- On i_memRspValid with dropCount = 0: write {data, PC} into the buffer tail, outstanding -= 1.
- The PC of each response is tracked in a per-request PC queue (or recomputed as headPc + 4*index). Either is acceptable if o_instrPc is exact.
- Credit guarantees the buffer never overflows. A response arriving with a full buffer is impossible; assert on it in simulation.

Decode handshake
- The buffer is a FIFO. o_instrValid = occupancy != 0.
- The head is removed on o_instrValid & i_instrReady.
- Push and pop in the same cycle leave occupancy unchanged.
- Zero-latency bypass is not required. Minimum fetch-to-decode latency is 1 cycle after the response.
- o_instr, o_instrPc and the field outputs are driven from the head entry. They are 0 when the buffer is empty.

Redirect (highest priority)
- On an i_redirectEn cycle:
  - buffer flushed;
  - a same-cycle decode pop has no effect;
  - fetchPc <= {i_redirectPc[31:2], 2'b00};
  - dropCount <= outstanding_next;
  - no request is issued.
- outstanding_next includes any request accepted in the previous cycle still pending. A response in the redirect cycle decrements both outstanding and the dropped population. That is, the response is discarded and dropCount is loaded with outstanding - 1.
- New fetches issue from the cycle after redirect, even while dropCount > 0, provided credit allows.
- Back-to-back redirects: the last one wins. dropCount is recomputed each time.

Test Plan:
1. Reset release, memory always ready, responses 1 cycle after request with data = address ^ 32'hA5A5_0000, decode always ready:
   - o_instrPc runs 0x0, 0x4, 0x8, ... with matching o_instr;
   - o_operand and o_funct3 equal the slices of o_instr;
   - outstanding never exceeds 2.
2. Decode stalled (i_instrReady = 0) for 20 cycles, DEPTH = 2:
   - exactly 2 requests are accepted, o_memReqValid then stays 0;
   - o_instrPc holds 0x0 until ready, then 0x4 follows.
3. Two requests outstanding (0x10, 0x14), i_redirectEn with i_redirectPc = 0x103 one cycle before the first response:
   - both responses are dropped;
   - the next delivered instruction has o_instrPc = 0x100;
   - o_memReqAddr = 0x100 the cycle after the redirect.
4. Redirect coincident with a response and with i_instrReady = 1:
   - buffer is empty the next cycle;
   - no stale PC is ever presented;
   - dropCount equals outstanding - 1.
5. Redirect to 32'hFFFF_FFFC, memory ready:
   - fetch addresses are 0xFFFF_FFFC then 0x0000_0000 (wrap).
6. i_arst asserted mid-stream with 2 requests outstanding:
   - outputs are at their reset values immediately, asynchronously;
   - after release, the first o_memReqAddr = RESET_PC;
   - late responses for old requests do not appear at decode.
